udma_ch_req_arbiter: RTL and testbench

- Responder side of the uDMA channel request/grant interface; address generators are the initiators.
- Each cycle, selects one requesting channel round-robin and returns a same-cycle grant plus a shared not-stall signal.
- Registers the winner's address, data size and channel ID into a single-entry output stage.
- Presents that stage to the L2 port with a req/gnt handshake and byte enables.

---
 rtl/udma_ch_req_arbiter_if.sv | 29 ++
 rtl/udma_ch_req_arbiter.sv | 92 +++++++++
 tb/tb_udma_ch_req_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/udma_ch_req_arbiter_if.sv
// Channel request/grant bundle plus the L2 output-stage handshake of the uDMA request arbiter.
// The slave modport is the arbiter; the master modport is the channel/L2 side.
interface udma_ch_req_arbiter_if #(
  parameter int N_CH           = 4,
  parameter int L2_AWIDTH_NOAL = 18,
  parameter int CH_IDW         = $clog2(N_CH)
);
  logic [N_CH-1:0]                ch_req_i;
  logic [N_CH*L2_AWIDTH_NOAL-1:0] ch_addr_i;
  logic [N_CH*2-1:0]              ch_datasize_i;
  logic [N_CH-1:0]                ch_gnt_o;
  logic                           not_stall_o;
  logic                           l2_req_o;
  logic                           l2_gnt_i;
  logic [L2_AWIDTH_NOAL-1:0]      l2_addr_o;
  logic [3:0]                     l2_be_o;
  logic [1:0]                     l2_datasize_o;
  logic [CH_IDW-1:0]              l2_chid_o;

  modport slave (
    input  ch_req_i, ch_addr_i, ch_datasize_i, l2_gnt_i,
    output ch_gnt_o, not_stall_o, l2_req_o, l2_addr_o, l2_be_o, l2_datasize_o, l2_chid_o
  );

  modport master (
    output ch_req_i, ch_addr_i, ch_datasize_i, l2_gnt_i,
    input  ch_gnt_o, not_stall_o, l2_req_o, l2_addr_o, l2_be_o, l2_datasize_o, l2_chid_o
  );
endinterface

// File: rtl/udma_ch_req_arbiter.sv
// Round-robin arbiter over uDMA channel requests feeding a single-entry L2 output stage.
// Grant is same-cycle; the stage holds stable while L2 withholds its grant.
module udma_ch_req_arbiter #(
  parameter int N_CH           = 4,
  parameter int L2_AWIDTH_NOAL = 18,
  parameter int CH_IDW         = $clog2(N_CH)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  udma_ch_req_arbiter_if.slave  bus
);

  logic [L2_AWIDTH_NOAL-1:0] w_addr_arr [N_CH];
  logic [1:0]                w_size_arr [N_CH];
  logic [N_CH-1:0]           w_gnt;
  logic [CH_IDW-1:0]         w_win;
  logic [CH_IDW-1:0]         w_idx;
  logic                      w_found;
  logic                      w_stall;
  logic                      w_grant_en;
  logic [3:0]                w_be;

  logic                      r_req;
  logic [L2_AWIDTH_NOAL-1:0] r_addr;
  logic [1:0]                r_size;
  logic [CH_IDW-1:0]         r_chid;
  logic [CH_IDW-1:0]         r_last;

  assign w_stall    = r_req && !bus.l2_gnt_i;
  // Grants are suppressed while in reset so the channel side sees a clean zero.
  assign w_grant_en = rstn_i && !w_stall && w_found;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_slice
      assign w_addr_arr[gi] = bus.ch_addr_i[gi*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL];
      assign w_size_arr[gi] = bus.ch_datasize_i[gi*2 +: 2];
      assign w_gnt[gi]      = w_grant_en && (w_win == CH_IDW'(gi));
    end
  endgenerate

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      w_idx = CH_IDW'((int'(r_last) + k) % N_CH);
      if (!w_found && bus.ch_req_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_req  <= 1'b0;
      r_addr <= '0;
      r_size <= '0;
      r_chid <= '0;
      r_last <= CH_IDW'(N_CH - 1);
    end else if (!w_stall) begin
      r_req <= w_found;
      if (w_found) begin
        r_addr <= w_addr_arr[w_win];
        r_size <= w_size_arr[w_win];
        r_chid <= w_win;
        r_last <= w_win;
      end
    end
  end

  always_comb begin
    w_be = 4'b0000;
    if (r_req) begin
      case (r_size)
        2'b00:   w_be = 4'b0001 << r_addr[1:0];
        2'b01:   w_be = 4'b0011 << {r_addr[1], 1'b0};
        2'b10:   w_be = 4'b1111;
        default: w_be = 4'b0000;
      endcase
    end
  end

  assign bus.ch_gnt_o      = w_gnt;
  assign bus.not_stall_o   = !w_stall;
  assign bus.l2_req_o      = r_req;
  assign bus.l2_addr_o     = r_addr;
  assign bus.l2_be_o       = w_be;
  assign bus.l2_datasize_o = r_size;
  assign bus.l2_chid_o     = r_chid;

endmodule

// File: tb/tb_udma_ch_req_arbiter.sv
// Directed bench for udma_ch_req_arbiter: a transaction-level model checked every negedge,
// plus literal expectations taken from hand-worked scenarios.
module tb_udma_ch_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 18;
  localparam int IW = 2;

  logic clk;
  logic rstn;
  int   n_checks = 0;
  int   n_fail   = 0;

  udma_ch_req_arbiter_if #(.N_CH(N), .L2_AWIDTH_NOAL(AW), .CH_IDW(IW)) bus ();

  udma_ch_req_arbiter #(.N_CH(N), .L2_AWIDTH_NOAL(AW), .CH_IDW(IW)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: what sits in the output stage and who was served last.
  logic          m_v;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_size;
  int            m_chid;
  int            m_last;

  function automatic int pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [AW-1:0] addr);
    int a;
    a = int'(addr[1:0]);
    case (size)
      2'd0:    return 4'(1 << a);
      2'd1:    return 4'(3 << (a & 2));
      2'd2:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rstn) begin
    int w;
    if (!rstn) begin
      m_v = 1'b0; m_addr = '0; m_size = '0; m_chid = 0; m_last = N - 1;
    end else if (!(m_v && !bus.l2_gnt_i)) begin
      w = pick(bus.ch_req_i, m_last);
      if (w >= 0) begin
        m_v    = 1'b1;
        m_addr = bus.ch_addr_i[w*AW +: AW];
        m_size = bus.ch_datasize_i[w*2 +: 2];
        m_chid = w;
        m_last = w;
      end else begin
        m_v = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic        stall;
    int          w;
    logic [31:0] eg;
    stall = m_v && !bus.l2_gnt_i;
    w     = pick(bus.ch_req_i, m_last);
    eg    = (rstn && !stall && w >= 0) ? (32'd1 << w) : 32'd0;
    check("m_gnt",      32'(bus.ch_gnt_o),      eg);
    check("m_notstall", 32'(bus.not_stall_o),   32'(!stall));
    check("m_req",      32'(bus.l2_req_o),      32'(m_v));
    check("m_addr",     32'(bus.l2_addr_o),     32'(m_addr));
    check("m_size",     32'(bus.l2_datasize_o), 32'(m_size));
    check("m_chid",     32'(bus.l2_chid_o),     32'(m_chid));
    check("m_be",       32'(bus.l2_be_o),       m_v ? 32'(be_of(m_size, m_addr)) : 32'd0);
    if (bus.l2_req_o && bus.l2_gnt_i)
      $display("xfer ch%0d addr=%05h size=%0d be=%b", bus.l2_chid_o, bus.l2_addr_o,
               bus.l2_datasize_o, bus.l2_be_o);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic [1:0] s);
    bus.ch_addr_i[ch*AW +: AW]  = a;
    bus.ch_datasize_i[ch*2 +: 2] = s;
  endtask

  logic [1:0]    be_size [4] = '{2'b01, 2'b01, 2'b00, 2'b11};
  logic [AW-1:0] be_addr [4] = '{18'h00003, 18'h00001, 18'h00002, 18'h00005};
  logic [3:0]    be_exp  [4] = '{4'b1100, 4'b0011, 4'b0100, 4'b0000};

  initial begin
    rstn = 1'b0;
    bus.ch_req_i = '0; bus.ch_addr_i = '0; bus.ch_datasize_i = '0; bus.l2_gnt_i = 1'b0;
    #2;
    check("rst_req",      32'(bus.l2_req_o),    32'd0);
    check("rst_notstall", 32'(bus.not_stall_o), 32'd1);
    check("rst_be",       32'(bus.l2_be_o),     32'd0);
    step(); step();
    rstn = 1'b1;

    // Single-beat forwarding
    set_ch(0, 18'h00103, 2'b00);
    bus.ch_req_i = 4'b0001; bus.l2_gnt_i = 1'b1;
    #2;
    check("fwd_gnt",      32'(bus.ch_gnt_o),    32'h1);
    check("fwd_notstall", 32'(bus.not_stall_o), 32'd1);
    step();
    bus.ch_req_i = 4'b0000;
    #2;
    check("fwd_req",  32'(bus.l2_req_o),  32'd1);
    check("fwd_addr", 32'(bus.l2_addr_o), 32'h00103);
    check("fwd_be",   32'(bus.l2_be_o),   32'b1000);
    check("fwd_chid", 32'(bus.l2_chid_o), 32'd0);
    step();

    // Round-robin from a fresh pointer
    rstn = 1'b0; #2; rstn = 1'b1;
    for (int c = 0; c < N; c++) set_ch(c, 18'(32'h00100 * (c + 1)), 2'b10);
    bus.ch_req_i = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #2;
      check("rr_gnt", 32'(bus.ch_gnt_o), 32'd1 << (k % 4));
      step();
      check("rr_chid", 32'(bus.l2_chid_o), 32'(k % 4));
    end

    // Stall hold on ch2's stage
    set_ch(2, 18'h00040, 2'b10);
    #2;
    check("st_gnt2", 32'(bus.ch_gnt_o), 32'b0100);
    step();
    bus.l2_gnt_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      check("st_notstall", 32'(bus.not_stall_o), 32'd0);
      check("st_gnt",      32'(bus.ch_gnt_o),    32'd0);
      check("st_addr",     32'(bus.l2_addr_o),   32'h00040);
      check("st_be",       32'(bus.l2_be_o),     32'hF);
      step();
    end
    bus.l2_gnt_i = 1'b1;
    #2;
    check("st_release", 32'(bus.not_stall_o), 32'd1);
    check("st_gnt3",    32'(bus.ch_gnt_o),    32'b1000);
    step();

    // Byte-enable table through ch1
    bus.ch_req_i = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      set_ch(1, be_addr[k], be_size[k]);
      #2;
      check("be_gnt", 32'(bus.ch_gnt_o), 32'b0010);
      step();
      check("be_req", 32'(bus.l2_req_o), 32'd1);
      check("be_val", 32'(bus.l2_be_o),  32'(be_exp[k]));
    end

    // Idle bubble
    set_ch(1, 18'h00123, 2'b00);
    step();
    bus.ch_req_i = 4'b0000;
    #2;
    check("idle_req1",  32'(bus.l2_req_o),  32'd1);
    check("idle_addr1", 32'(bus.l2_addr_o), 32'h00123);
    step();
    check("idle_req0",  32'(bus.l2_req_o),  32'd0);
    check("idle_addr0", 32'(bus.l2_addr_o), 32'h00123);
    check("idle_be0",   32'(bus.l2_be_o),   32'd0);
    step();

    // Asynchronous reset while the stage is stalled
    bus.ch_req_i = 4'b0001; bus.l2_gnt_i = 1'b0;
    step();
    #2;
    check("ar_req_pre",  32'(bus.l2_req_o),    32'd1);
    check("ar_stall",    32'(bus.not_stall_o), 32'd0);
    rstn = 1'b0;
    #1;
    check("ar_req",      32'(bus.l2_req_o),      32'd0);
    check("ar_addr",     32'(bus.l2_addr_o),     32'd0);
    check("ar_size",     32'(bus.l2_datasize_o), 32'd0);
    check("ar_chid",     32'(bus.l2_chid_o),     32'd0);
    check("ar_gnt",      32'(bus.ch_gnt_o),      32'd0);
    check("ar_be",       32'(bus.l2_be_o),       32'd0);
    check("ar_notstall", 32'(bus.not_stall_o),   32'd1);
    step(); step();
    rstn = 1'b1;
    bus.ch_req_i = 4'b1010; bus.l2_gnt_i = 1'b1;
    #2;
    check("ar_first_gnt", 32'(bus.ch_gnt_o), 32'b0010);
    step();
    check("ar_first_chid", 32'(bus.l2_chid_o), 32'd1);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
